// File: rtl/trade_pkg.sv
// Shared types for the trading pipeline: FSM states, order side and order payload.
package trade_pkg;

  localparam int OG_DATA_W = 8;
  localparam int OG_POS_W  = 16;
  localparam int OG_ID_W   = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    COOLDOWN = 2'd2
  } og_state_t;

  typedef enum logic {
    SIDE_SELL = 1'b0,
    SIDE_BUY  = 1'b1
  } side_t;

  typedef struct packed {
    side_t                 side;
    logic [OG_POS_W-1:0]   qty;
    logic [OG_DATA_W-1:0]  price;
    logic [OG_ID_W-1:0]    id;
  } order_t;

endpackage

// File: rtl/position_limit_check.sv
// Combinational symmetric position-limit check: would a fill of qty on the
// given side keep |position| within MAX_POS? Uses one extra bit so the
// candidate position never wraps.
module position_limit_check
  import trade_pkg::*;
#(
  parameter int POS_WIDTH = 16,
  parameter int MAX_POS   = 8
) (
  input  logic signed [POS_WIDTH-1:0] position,
  input  side_t                       side,
  input  logic        [POS_WIDTH-1:0] qty,
  output logic                        ok
);

  localparam logic signed [POS_WIDTH:0] LIMIT = (POS_WIDTH+1)'(MAX_POS);

  logic signed [POS_WIDTH:0] pos_ext;
  logic signed [POS_WIDTH:0] qty_ext;
  logic signed [POS_WIDTH:0] after_buy;
  logic signed [POS_WIDTH:0] after_sell;

  assign pos_ext    = {position[POS_WIDTH-1], position};
  assign qty_ext    = {1'b0, qty};
  assign after_buy  = pos_ext + qty_ext;
  assign after_sell = pos_ext - qty_ext;
  assign ok         = (side == SIDE_BUY) ? (after_buy <= LIMIT) : (after_sell >= -LIMIT);

endmodule

// File: rtl/order_gen.sv
// Order generator: turns buy/sell decisions into single valid/ready order
// transactions, enforcing a position limit and a post-order cooldown while
// tracking net position and counting dropped decisions.
module order_gen
  import trade_pkg::*;
#(
  parameter int data_width      = 8,
  parameter int POS_WIDTH       = 16,
  parameter int ORDER_QTY       = 1,
  parameter int MAX_POS         = 8,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int ID_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         sig_valid,
  input  logic                         buy_in,
  input  logic                         sell_in,
  input  logic        [data_width-1:0] price_in,
  output logic                         order_valid,
  input  logic                         order_ready,
  output logic                         order_side,
  output logic        [POS_WIDTH-1:0]  order_qty,
  output logic        [data_width-1:0] order_price,
  output logic        [ID_WIDTH-1:0]   order_id,
  output logic signed [POS_WIDTH-1:0]  position,
  output logic        [15:0]           drop_count,
  output logic                         busy
);

  localparam int CNT_W = (COOLDOWN_CYCLES < 1) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [POS_WIDTH-1:0] QTY = POS_WIDTH'(ORDER_QTY);

  og_state_t              state;
  og_state_t              state_next;
  side_t                  side_q;
  side_t                  dec_side;
  logic [CNT_W-1:0]       cd_cnt;
  logic                   decision;
  logic                   request;
  logic                   limit_ok;
  logic                   take;
  logic                   fire;
  logic                   drop;

  assign decision    = sig_valid && enable && (buy_in ^ sell_in);
  assign request     = sig_valid && enable && (buy_in | sell_in);
  assign dec_side    = buy_in ? SIDE_BUY : SIDE_SELL;
  assign order_valid = (state == SEND);
  assign busy        = (state != IDLE);
  assign order_side  = side_q;

  position_limit_check #(
    .POS_WIDTH (POS_WIDTH),
    .MAX_POS   (MAX_POS)
  ) u_limit (
    .position (position),
    .side     (dec_side),
    .qty      (QTY),
    .ok       (limit_ok)
  );

  // Next-state logic plus the accept/handshake/drop strobes for this cycle
  always_comb begin
    state_next = state;
    take       = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (decision && limit_ok) begin
          take       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (order_ready) begin
          fire       = 1'b1;
          state_next = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cd_cnt == CNT_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    drop = request && ((state != IDLE) || (buy_in && sell_in) || !limit_ok);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Payload latch, position/id update on handshake, cooldown counter and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      side_q      <= SIDE_SELL;
      order_qty   <= '0;
      order_price <= '0;
      order_id    <= '0;
      position    <= '0;
      drop_count  <= '0;
      cd_cnt      <= '0;
    end else begin
      if (take) begin
        side_q      <= dec_side;
        order_qty   <= QTY;
        order_price <= price_in;
      end
      if (fire) begin
        position <= (side_q == SIDE_BUY) ? position + $signed(order_qty)
                                         : position - $signed(order_qty);
        order_id <= order_id + ID_WIDTH'(1);
        cd_cnt   <= CNT_W'(COOLDOWN_CYCLES);
      end else if (state == COOLDOWN) begin
        cd_cnt <= cd_cnt - CNT_W'(1);
      end
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_order_gen.sv
// Scoreboard bench for order_gen: directed scenarios followed by random traffic,
// checked against a transaction-level reference model.
module tb_order_gen;

  localparam int ID_W    = 2;
  localparam int MAXP    = 8;
  localparam int COOL    = 4;
  localparam int QTYV    = 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               sig_valid = 1'b0;
  logic               buy_in = 1'b0;
  logic               sell_in = 1'b0;
  logic [7:0]         price_in = '0;
  logic               order_ready = 1'b0;
  logic               order_valid;
  logic               order_side;
  logic [15:0]        order_qty;
  logic [7:0]         order_price;
  logic [ID_W-1:0]    order_id;
  logic signed [15:0] position;
  logic [15:0]        drop_count;
  logic               busy;

  order_gen #(.ID_WIDTH(ID_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sig_valid(sig_valid),
    .buy_in(buy_in), .sell_in(sell_in), .price_in(price_in),
    .order_valid(order_valid), .order_ready(order_ready),
    .order_side(order_side), .order_qty(order_qty), .order_price(order_price),
    .order_id(order_id), .position(position), .drop_count(drop_count), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit side;
    int price;
    int id;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_pos = 0;
  int   m_id = 0;
  int   m_drops = 0;
  int   m_cd = 0;
  bit   m_out = 0;
  bit   m_side = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance one clock edge using the inputs that were applied before it
  task automatic modelStep();
    bit busy_pre, req, drop_now, pass;
    int pos_pre, id_pre, cd_pre;
    bit out_pre;
    if (rst) begin
      exp_q.delete();
      m_pos = 0; m_id = 0; m_drops = 0; m_cd = 0; m_out = 0;
      return;
    end
    busy_pre = m_out || (m_cd > 0);
    out_pre  = m_out;
    cd_pre   = m_cd;
    pos_pre  = m_pos;
    id_pre   = m_id;
    req      = sig_valid && enable && (buy_in || sell_in);
    drop_now = 0;
    if (out_pre && order_ready) begin
      m_pos = m_pos + (m_side ? QTYV : -QTYV);
      m_id  = (m_id + 1) % (1 << ID_W);
      m_out = 0;
      m_cd  = COOL;
    end else if (!out_pre && cd_pre > 0) begin
      m_cd = cd_pre - 1;
    end
    if (req) begin
      if (busy_pre || (buy_in && sell_in)) drop_now = 1;
      else begin
        pass = buy_in ? (pos_pre + QTYV <= MAXP) : (pos_pre - QTYV >= -MAXP);
        if (!pass) drop_now = 1;
        else begin
          m_out  = 1;
          m_side = buy_in;
          exp_q.push_back('{buy_in, int'(price_in), id_pre});
        end
      end
    end
    if (drop_now && m_drops < 65535) m_drops++;
  endtask

  // One cycle: drive inputs, let the edge pass, update the model and compare state outputs
  task automatic applyStimulus(input bit r, input bit en, input bit sv, input bit b,
                               input bit s, input logic [7:0] p, input bit rdy);
    rst = r; enable = en; sig_valid = sv; buy_in = b; sell_in = s;
    price_in = p; order_ready = rdy;
    @(posedge clk);
    #2;
    modelStep();
    checkOutput("position",   longint'(position), m_pos);
    checkOutput("drop_count", drop_count, m_drops);
    checkOutput("order_valid", order_valid, m_out);
    checkOutput("busy",       busy, (m_out || m_cd > 0));
    checkOutput("order_id",   order_id, m_id);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 8'h00, rdy);
  endtask

  // Monitor: compare every presented payload with the scoreboard head, pop on handshake
  always @(negedge clk) begin
    exp_t e;
    if (order_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_order: got side=%0d price=%0d id=%0d expected none",
                 order_side, order_price, order_id);
      end else begin
        e = exp_q[0];
        checkOutput("order_side",  order_side, e.side);
        checkOutput("order_price", order_price, e.price);
        checkOutput("order_payload_id", order_id, e.id);
        checkOutput("order_qty",   order_qty, QTYV);
        if (order_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    // reset state
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("reset_valid", order_valid, 0);
    checkOutput("reset_pos", longint'(position), 0);

    // basic buy
    applyStimulus(0, 1, 1, 1, 0, 8'h64, 1);
    checkOutput("t1_valid", order_valid, 1);
    checkOutput("t1_price", order_price, 8'h64);
    idle(1, 1);
    checkOutput("t1_pos", longint'(position), 1);
    idle(5, 1);

    // backpressure
    applyStimulus(0, 1, 1, 1, 0, 8'h3A, 0);
    idle(5, 0);
    checkOutput("t2_pos_hold", longint'(position), 1);
    idle(1, 1);
    checkOutput("t2_pos_after", longint'(position), 2);
    idle(5, 1);

    // limit: nine buys from a clean position
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, 1, 1, 1, 0, 8'(k + 10), 1);
      idle(6, 1);
    end
    checkOutput("t3_pos_limit", longint'(position), 8);
    checkOutput("t3_drops", drop_count, 1);
    applyStimulus(0, 1, 1, 0, 1, 8'h55, 1);
    idle(6, 1);
    checkOutput("t3_pos_sell", longint'(position), 7);

    // conflict, then busy drop during cooldown
    applyStimulus(0, 1, 1, 1, 1, 8'h11, 1);
    idle(1, 1);
    checkOutput("t4_conflict", drop_count, 2);
    applyStimulus(0, 1, 1, 1, 0, 8'h22, 1);
    idle(1, 1);
    applyStimulus(0, 1, 1, 1, 0, 8'h23, 1);
    checkOutput("t4_busy_drop", drop_count, 3);
    idle(6, 1);

    // reset in the middle of SEND with the gateway stalled
    applyStimulus(0, 1, 1, 0, 1, 8'h77, 0);
    idle(2, 0);
    applyStimulus(1, 1, 0, 0, 0, 8'h00, 0);
    checkOutput("t5_valid", order_valid, 0);
    checkOutput("t5_pos", longint'(position), 0);
    checkOutput("t5_id", order_id, 0);
    checkOutput("t5_busy", busy, 0);

    // kill switch, then id wrap over five orders
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 1, 0, 8'h40, 1);
    checkOutput("t6_kill_drops", drop_count, 0);
    checkOutput("t6_kill_valid", order_valid, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 1, 1, 0, 8'(k + 200), 1);
      idle(6, 1);
    end
    checkOutput("t6_id_wrap", order_id, 1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    8'($urandom), ($urandom_range(0, 3) != 0));
    end

    // drain any order still in flight
    idle(10, 1);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
